// File: rtl/amstrad_uart_pkg.sv
// Shared constants for the Amstrad serial interface: register map, status bits,
// FSM state encodings and the half-bit sample helper.
package amstrad_uart_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'hFADC;
  localparam logic [15:0] ADDR_STAT   = 16'hFADD;
  localparam logic [15:0] ADDR_DIV_LO = 16'hFADE;
  localparam logic [15:0] ADDR_DIV_HI = 16'hFADF;

  localparam int unsigned DIV_RESET_DEFAULT = 415;

  // Status read bit positions
  localparam int unsigned ST_RX_AVAIL = 0;
  localparam int unsigned ST_TX_READY = 1;
  localparam int unsigned ST_OVERRUN  = 2;
  localparam int unsigned ST_FRAMING  = 3;
  localparam int unsigned ST_IRQ_EN   = 4;

  // Control write bit positions
  localparam int unsigned CTRL_CLR_ERR = 0;
  localparam int unsigned CTRL_IRQ_EN  = 4;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t TX_IDLE  = 2'd0;
  localparam uart_state_t TX_START = 2'd1;
  localparam uart_state_t TX_DATA  = 2'd2;
  localparam uart_state_t TX_STOP  = 2'd3;

  localparam uart_state_t RX_IDLE  = 2'd0;
  localparam uart_state_t RX_START = 2'd1;
  localparam uart_state_t RX_DATA  = 2'd2;
  localparam uart_state_t RX_STOP  = 2'd3;

  // Counter reload that lands the start-bit sample (divisor+1)/2 ticks in
  function automatic logic [15:0] half_bit(input logic [15:0] div);
    logic [16:0] h;
    h = (17'(div) + 17'd1) >> 1;
    return (h == 17'd0) ? 16'd0 : 16'(h - 17'd1);
  endfunction

endpackage

// File: rtl/amstrad_uart_fifo.sv
// Synchronous receive FIFO with power-of-two depth; pops and pushes on a
// full/empty boundary are ignored rather than corrupting state.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (do_pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/amstrad_uart.sv
// Amstrad CPC style serial interface at &FADC-&FADF: 8N1 transmitter with a
// single holding register, receiver feeding a small FIFO, programmable divisor.
module amstrad_uart
  import amstrad_uart_pkg::*;
#(
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_4p,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  io_din,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [7:0]  io_dout,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);

  localparam int unsigned CW = $clog2(RX_DEPTH) + 1;

  logic        sel_data, sel_stat, sel_dlo, sel_dhi;
  logic        io_wr_q, rd_data_q, wr_edge;
  logic [15:0] divisor;
  logic [7:0]  hold;
  logic        hold_full;
  logic        overrun, framing, rx_irq_en;
  logic        rxd_s1, rxd_s2, rxd_s3;

  logic          rx_fifo_push, rx_fifo_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  uart_state_t tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [7:0]  tx_sh, tx_sh_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic        txd_d, tx_take, tx_end;

  uart_state_t rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [7:0]  rx_sh, rx_sh_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic        rx_push, rx_frame_err, rx_end;

  logic [7:0]  status;

  assign sel_data = (cpu_addr == ADDR_DATA);
  assign sel_stat = (cpu_addr == ADDR_STAT);
  assign sel_dlo  = (cpu_addr == ADDR_DIV_LO);
  assign sel_dhi  = (cpu_addr == ADDR_DIV_HI);
  assign wr_edge  = io_wr & ~io_wr_q;

  // Pop on the clk the data-register read strobe drops
  assign rx_fifo_pop  = rd_data_q & ~io_rd & ~rx_empty;
  assign rx_fifo_push = rx_push & ~rx_full;

  always_comb begin
    status              = 8'h00;
    status[ST_RX_AVAIL] = ~rx_empty;
    status[ST_TX_READY] = ~hold_full;
    status[ST_OVERRUN]  = overrun;
    status[ST_FRAMING]  = framing;
    status[ST_IRQ_EN]   = rx_irq_en;
  end

  always_comb begin
    io_dout = 8'hFF;
    if (io_rd) begin
      if (sel_data)     io_dout = rx_empty ? 8'hFF : rx_head;
      else if (sel_stat) io_dout = status;
      else if (sel_dlo)  io_dout = divisor[7:0];
      else if (sel_dhi)  io_dout = divisor[15:8];
    end
  end

  // CPU register file, strobe edge detect, receive synchroniser and flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      io_wr_q   <= 1'b0;
      rd_data_q <= 1'b0;
      divisor   <= 16'(DIV_RESET);
      hold      <= 8'h00;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      framing   <= 1'b0;
      rx_irq_en <= 1'b0;
      irq       <= 1'b0;
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_s3    <= 1'b1;
    end else begin
      io_wr_q   <= io_wr;
      rd_data_q <= io_rd & sel_data;
      irq       <= (rx_count != CW'(0)) & rx_irq_en;
      rxd_s1    <= uart_rxd;
      rxd_s2    <= rxd_s1;
      rxd_s3    <= rxd_s2;
      if (tx_take) hold_full <= 1'b0;
      if (wr_edge) begin
        if (sel_data && !hold_full) begin
          hold      <= io_din;
          hold_full <= 1'b1;
        end
        if (sel_stat) begin
          rx_irq_en <= io_din[CTRL_IRQ_EN];
          if (io_din[CTRL_CLR_ERR]) begin
            overrun <= 1'b0;
            framing <= 1'b0;
          end
        end
        if (sel_dlo) divisor[7:0]  <= io_din;
        if (sel_dhi) divisor[15:8] <= io_din;
      end
      // A new error event wins over a simultaneous clear
      if (rx_push && rx_full) overrun <= 1'b1;
      if (rx_frame_err)       framing <= 1'b1;
    end
  end

  // Transmit FSM: each state lasts divisor+1 ticks, reloaded at every bit boundary
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_sh_d    = tx_sh;
    tx_bit_d   = tx_bit;
    txd_d      = uart_txd;
    tx_take    = 1'b0;
    tx_end     = ce_4p && (tx_cnt == 16'd0);
    if (tx_state != TX_IDLE && ce_4p && tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
    case (tx_state)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (hold_full) begin
          tx_take    = 1'b1;
          tx_sh_d    = hold;
          tx_cnt_d   = divisor;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_cnt_d   = divisor;
          txd_d      = tx_sh[0];
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          tx_cnt_d = divisor;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_sh_d  = tx_sh >> 1;
            tx_bit_d = tx_bit + 3'd1;
            txd_d    = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          // A byte already waiting goes straight into its start bit
          if (hold_full) begin
            tx_take    = 1'b1;
            tx_sh_d    = hold;
            tx_cnt_d   = divisor;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            txd_d      = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        txd_d      = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_sh    <= 8'h00;
      tx_bit   <= 3'd0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_sh    <= tx_sh_d;
      tx_bit   <= tx_bit_d;
      uart_txd <= txd_d;
    end
  end

  // Receive FSM: a falling edge starts a frame, so a line held low after a
  // framing error cannot be mistaken for a new start bit
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_sh_d      = rx_sh;
    rx_bit_d     = rx_bit;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    rx_end       = ce_4p && (rx_cnt == 16'd0);
    if (rx_state != RX_IDLE && ce_4p && rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
    case (rx_state)
      RX_IDLE: begin
        if (rxd_s3 && !rxd_s2) begin
          rx_cnt_d   = half_bit(divisor);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_end) begin
          if (rxd_s2) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
            rx_cnt_d   = divisor;
          end
        end
      end
      RX_DATA: begin
        if (rx_end) begin
          rx_sh_d  = {rxd_s2, rx_sh[7:1]};
          rx_cnt_d = divisor;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_end) begin
          if (rxd_s2) rx_push      = 1'b1;
          else        rx_frame_err = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_sh    <= 8'h00;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_sh    <= rx_sh_d;
      rx_bit   <= rx_bit_d;
    end
  end

  uart_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_fifo_push),
    .pop     (rx_fifo_pop),
    .din     (rx_sh),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

endmodule

// File: tb/tb_amstrad_uart.sv
// Bench for amstrad_uart: register table, TX frame scoreboard via a line
// monitor, RX scoreboard checked on data-register reads, reset corner cases.
module tb_amstrad_uart;
  import amstrad_uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_4p;
  logic [15:0] cpu_addr;
  logic [7:0]  io_din;
  logic        io_wr;
  logic        io_rd;
  logic [7:0]  io_dout;
  logic        uart_rxd;
  logic        uart_txd;
  logic        irq;

  amstrad_uart #(.RX_DEPTH(8), .DIV_RESET(415)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_4p    (ce_4p),
    .cpu_addr (cpu_addr),
    .io_din   (io_din),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_dout  (io_dout),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       tx_mon_on = 1'b1;
  int         frames_done = 0;
  int         last_gap = -1;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  // One ce_4p pulse every fourth clk, changed just after the edge
  initial begin
    int n;
    n = 0;
    ce_4p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      ce_4p = (n % 4 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ce();
    do @(posedge clk); while (ce_4p !== 1'b1);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(posedge clk);
    #1;
    cpu_addr = a;
    io_din   = d;
    io_wr    = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    io_wr = 1'b0;
    @(posedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_addr = a;
    io_rd    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    d = io_dout;
    @(posedge clk);
    #1;
    io_rd = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_stat(input string name, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(ADDR_STAT, d);
    chk(name, 40'(d), 40'(exp));
  endtask

  task automatic read_data_chk(input string name);
    logic [7:0] d;
    logic [7:0] exp;
    exp = (rx_q.size() == 0) ? 8'hFF : rx_q.pop_front();
    cpu_read(ADDR_DATA, d);
    chk(name, 40'(d), 40'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned div);
    #1 uart_rxd = 1'b0;
    repeat (div + 1) wait_ce();
    for (int i = 0; i < 8; i++) begin
      #1 uart_rxd = b[i];
      repeat (div + 1) wait_ce();
    end
    #1 uart_rxd = stop;
    repeat (div + 1) wait_ce();
    #1 uart_rxd = 1'b1;
    repeat (2) wait_ce();
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 0;
    while (frames_done < n && budget < 400) begin
      wait_ce();
      budget++;
    end
    chk("tx_frames_seen", 40'(frames_done), 40'(n));
  endtask

  // TX line monitor: 40 ce-samples per frame compared with the queued byte
  initial begin
    logic [39:0] s, exp;
    logic [7:0]  b;
    int n, gap;
    gap = 0;
    forever begin
      @(negedge clk);
      if (tx_mon_on && reset_n === 1'b1) begin
        if (uart_txd === 1'b0) begin
          last_gap = gap;
          gap = 0;
          n = 0;
          s = '0;
          while (1) begin
            if (ce_4p) begin
              s[n] = uart_txd;
              n++;
            end
            if (n == 40) break;
            @(negedge clk);
          end
          if (tx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected_frame: got %h expected no frame", s);
          end else begin
            b = tx_q.pop_front();
            for (int i = 0; i < 40; i++)
              exp[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b[(i - 4) / 4];
            chk("tx_frame", s, exp);
          end
          frames_done++;
        end else if (ce_4p) begin
          gap++;
        end
      end
    end
  end

  initial begin
    vec_t vecs[17];
    logic [7:0] d;
    int f0;

    vecs[0]  = '{1'b0, 16'hFADD, 8'h02};
    vecs[1]  = '{1'b0, 16'hFADE, 8'h9F};
    vecs[2]  = '{1'b0, 16'hFADF, 8'h01};
    vecs[3]  = '{1'b0, 16'hFADC, 8'hFF};
    vecs[4]  = '{1'b0, 16'hFADB, 8'hFF};
    vecs[5]  = '{1'b0, 16'h0ADD, 8'hFF};
    vecs[6]  = '{1'b1, 16'hFADE, 8'h03};
    vecs[7]  = '{1'b1, 16'hFADF, 8'h00};
    vecs[8]  = '{1'b1, 16'h7ADE, 8'h55};
    vecs[9]  = '{1'b0, 16'hFADE, 8'h03};
    vecs[10] = '{1'b0, 16'hFADF, 8'h00};
    vecs[11] = '{1'b1, 16'hFADD, 8'h10};
    vecs[12] = '{1'b0, 16'hFADD, 8'h12};
    vecs[13] = '{1'b1, 16'hFADD, 8'h00};
    vecs[14] = '{1'b0, 16'hFADD, 8'h02};
    vecs[15] = '{1'b1, 16'hFBDF, 8'h22};
    vecs[16] = '{1'b0, 16'hFADF, 8'h00};

    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    io_din   = 8'h00;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", 40'(uart_txd), 40'd1);
    chk("reset_irq", 40'(irq), 40'd0);
    reset_n = 1'b1;

    // Register map, decode and reset values
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        cpu_write(vecs[i].addr, vecs[i].data, 4);
      end else begin
        cpu_read(vecs[i].addr, d);
        chk($sformatf("reg_vec%0d", i), 40'(d), 40'(vecs[i].data));
      end
    end
    cpu_addr = ADDR_STAT;
    @(negedge clk);
    chk("dout_idle_ff", 40'(io_dout), 40'hFF);

    // Single byte &41 at divisor 3; holding register frees at start bit
    tx_q.push_back(8'h41);
    cpu_write(ADDR_DATA, 8'h41, 4);
    read_stat("tx_ready_in_frame", 8'h02);
    chk("txd_low_in_start", 40'(uart_txd), 40'd0);
    wait_frames(1);

    // Back-to-back: second byte reloads holding reg, third is discarded
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    cpu_write(ADDR_DATA, 8'h3C, 4);
    cpu_write(ADDR_DATA, 8'hC3, 4);
    read_stat("tx_busy_status", 8'h00);
    cpu_write(ADDR_DATA, 8'h77, 4);
    wait_frames(3);
    chk("tx_no_gap", 40'(last_gap), 40'd0);

    // Held write strobe sends exactly one byte
    tx_q.push_back(8'h96);
    cpu_write(ADDR_DATA, 8'h96, 12);
    wait_frames(4);
    repeat (60) wait_ce();
    chk("tx_single_on_hold", 40'(frames_done), 40'd4);
    chk("txd_idle_high", 40'(uart_txd), 40'd1);

    // Receive &A5 with interrupts enabled
    cpu_write(ADDR_STAT, 8'h10, 4);
    rx_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 3);
    read_stat("rx_avail", 8'h13);
    chk("irq_set", 40'(irq), 40'd1);
    read_data_chk("rx_a5");
    read_stat("rx_popped", 8'h12);
    chk("irq_clear", 40'(irq), 40'd0);

    // Short low pulse at divisor 7 is rejected as a glitch
    cpu_write(ADDR_DIV_LO, 8'h07, 4);
    #1 uart_rxd = 1'b0;
    repeat (2) wait_ce();
    #1 uart_rxd = 1'b1;
    repeat (30) wait_ce();
    read_stat("glitch_rejected", 8'h12);
    cpu_write(ADDR_DIV_LO, 8'h03, 4);

    // Stop bit low: framing error, nothing queued; clear clears irq_en too
    send_byte(8'h55, 1'b0, 3);
    repeat (4) wait_ce();
    read_stat("framing_err", 8'h1A);
    cpu_write(ADDR_STAT, 8'h01, 4);
    read_stat("framing_cleared", 8'h02);

    // Nine bytes into an 8-deep FIFO: ninth dropped, overrun; transmitter idle
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) rx_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, 3);
    end
    read_stat("overrun_status", 8'h07);
    for (int i = 0; i < 9; i++) read_data_chk($sformatf("rx_fifo_rd%0d", i));
    read_stat("overrun_sticky", 8'h06);
    cpu_write(ADDR_STAT, 8'h01, 4);
    read_stat("overrun_cleared", 8'h02);
    chk("rx_q_drained", 40'(rx_q.size()), 40'd0);
    chk("tx_q_drained", 40'(tx_q.size()), 40'd0);

    // Reset in the middle of a TX frame of zeros and an RX frame
    tx_mon_on = 1'b0;
    f0 = frames_done;
    cpu_write(ADDR_DATA, 8'h00, 4);
    fork
      send_byte(8'h00, 1'b1, 3);
      begin
        repeat (12) wait_ce();
        chk("txd_low_before_reset", 40'(uart_txd), 40'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_txd", 40'(uart_txd), 40'd1);
        chk("mid_reset_irq", 40'(irq), 40'd0);
        chk("mid_reset_dout", 40'(io_dout), 40'hFF);
        reset_n = 1'b1;
        read_stat("mid_reset_status", 8'h02);
        cpu_read(ADDR_DIV_LO, d);
        chk("mid_reset_div_lo", 40'(d), 40'h9F);
        cpu_read(ADDR_DIV_HI, d);
        chk("mid_reset_div_hi", 40'(d), 40'h01);
        chk("mid_reset_txd_after", 40'(uart_txd), 40'd1);
      end
    join
    chk("no_frames_while_off", 40'(frames_done), 40'(f0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
